// File: rtl/gmii_rx_pkg.sv
// Shared constants for the GMII receive path: framing bytes, CRC-32 parameters,
// FSM state encodings and RX_STATUS bit positions.
package gmii_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_IDLE = 2'd0;
  localparam rx_state_t ST_PRE  = 2'd1;
  localparam rx_state_t ST_DATA = 2'd2;
  localparam rx_state_t ST_DROP = 2'd3;

  localparam int STAT_CRC_BAD  = 0;
  localparam int STAT_RUNT     = 1;
  localparam int STAT_TOO_LONG = 2;
  localparam int STAT_ER       = 3;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state function for the reflected Ethernet CRC-32, LSB of the
// data byte first. Shared with the TX FCS inserter.
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, validates CRC, length and RX_ER,
// and forwards the payload with the FCS held back in a 4-byte delay line.
module gmii_rx_frame_checker
  import gmii_rx_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             GMII_CLK,
  input  logic             RESET_IN,
  input  logic             GMII_RX_DV,
  input  logic [7:0]       GMII_RXD,
  input  logic             GMII_RX_ER,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  output logic             RX_SOF,
  output logic             RX_END,
  output logic             RX_GOOD,
  output logic [3:0]       RX_STATUS,
  output logic [CNT_W-1:0] GOOD_CNT,
  output logic [CNT_W-1:0] BAD_CNT
);

  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] CNT_SAT   = 11'h7FF;

  logic            dv_q;
  logic            er_q;
  logic [7:0]      rxd_q;

  rx_state_t       state;
  logic [2:0]      pcnt;
  logic [31:0]     crc;
  logic [31:0]     crc_next;
  logic [10:0]     byte_cnt;
  logic [3:0][7:0] dline;
  logic            er_seen;
  logic [3:0]      status_now;

  always_ff @(posedge GMII_CLK) begin
    if (RESET_IN) begin
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      rxd_q <= 8'h00;
    end else begin
      dv_q  <= GMII_RX_DV;
      er_q  <= GMII_RX_ER;
      rxd_q <= GMII_RXD;
    end
  end

  crc32_d8 u_crc (
    .data    (rxd_q),
    .crc_in  (crc),
    .crc_out (crc_next)
  );

  always_comb begin
    status_now                = 4'b0000;
    status_now[STAT_CRC_BAD]  = (crc != CRC_RESIDUE);
    status_now[STAT_RUNT]     = (byte_cnt < MIN_LEN_C);
    status_now[STAT_TOO_LONG] = (byte_cnt > MAX_LEN_C);
    status_now[STAT_ER]       = er_seen;
  end

  // A byte leaves the delay line only when a newer one pushes it out, so the
  // last four bytes (the FCS) are never forwarded.
  always_ff @(posedge GMII_CLK) begin
    if (RESET_IN) begin
      state     <= ST_IDLE;
      pcnt      <= 3'd0;
      crc       <= CRC_INIT;
      byte_cnt  <= 11'd0;
      dline     <= '0;
      er_seen   <= 1'b0;
      RX_DATA   <= 8'h00;
      RX_VALID  <= 1'b0;
      RX_SOF    <= 1'b0;
      RX_END    <= 1'b0;
      RX_GOOD   <= 1'b0;
      RX_STATUS <= 4'b0000;
      GOOD_CNT  <= '0;
      BAD_CNT   <= '0;
    end else begin
      RX_VALID  <= 1'b0;
      RX_SOF    <= 1'b0;
      RX_END    <= 1'b0;
      RX_GOOD   <= 1'b0;
      RX_STATUS <= 4'b0000;
      case (state)
        ST_IDLE: begin
          if (dv_q) begin
            if (rxd_q == PREAMBLE_BYTE) begin
              state <= ST_PRE;
              pcnt  <= 3'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!dv_q) begin
            state <= ST_IDLE;
          end else if (rxd_q == PREAMBLE_BYTE) begin
            if (pcnt != 3'd7) pcnt <= pcnt + 3'd1;
          end else if (rxd_q == SFD_BYTE) begin
            state    <= ST_DATA;
            crc      <= CRC_INIT;
            byte_cnt <= 11'd0;
            er_seen  <= 1'b0;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (dv_q) begin
            crc     <= crc_next;
            dline   <= {dline[2:0], rxd_q};
            er_seen <= er_seen | er_q;
            if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt >= 11'd4 && byte_cnt < MAX_LEN_C) begin
              RX_DATA  <= dline[3];
              RX_VALID <= 1'b1;
              RX_SOF   <= (byte_cnt == 11'd4);
            end
          end else begin
            state     <= ST_IDLE;
            RX_END    <= 1'b1;
            RX_STATUS <= status_now;
            RX_GOOD   <= (status_now == 4'b0000);
            if (status_now == 4'b0000) begin
              if (GOOD_CNT != {CNT_W{1'b1}}) GOOD_CNT <= GOOD_CNT + CNT_W'(1);
            end else begin
              if (BAD_CNT != {CNT_W{1'b1}}) BAD_CNT <= BAD_CNT + CNT_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (!dv_q) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Directed self-checking bench for gmii_rx_frame_checker: one task per scenario,
// expected values built from hand-chosen frames and a reference CRC-32.
module tb_gmii_rx_frame_checker;

  localparam int CNT_W = 16;

  logic             GMII_CLK = 1'b0;
  logic             RESET_IN;
  logic             GMII_RX_DV;
  logic [7:0]       GMII_RXD;
  logic             GMII_RX_ER;
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic             RX_SOF;
  logic             RX_END;
  logic             RX_GOOD;
  logic [3:0]       RX_STATUS;
  logic [CNT_W-1:0] GOOD_CNT;
  logic [CNT_W-1:0] BAD_CNT;

  gmii_rx_frame_checker #(.MAX_LEN(1518), .MIN_LEN(64), .CNT_W(CNT_W)) dut (
    .GMII_CLK   (GMII_CLK),
    .RESET_IN   (RESET_IN),
    .GMII_RX_DV (GMII_RX_DV),
    .GMII_RXD   (GMII_RXD),
    .GMII_RX_ER (GMII_RX_ER),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .RX_SOF     (RX_SOF),
    .RX_END     (RX_END),
    .RX_GOOD    (RX_GOOD),
    .RX_STATUS  (RX_STATUS),
    .GOOD_CNT   (GOOD_CNT),
    .BAD_CNT    (BAD_CNT)
  );

  always #4 GMII_CLK = ~GMII_CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge GMII_CLK) cyc <= cyc + 1;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame[$];
  int         end_cnt = 0;
  int         sof_cnt = 0;
  int         end_valid_cnt = 0;
  int         first_valid_cyc = -1;
  int         drive_cyc0 = 0;
  logic [7:0] sof_byte = 8'h00;
  logic       last_good = 1'b0;
  logic [3:0] last_status = 4'h0;

  // Passive collector of everything the DUT emits, sampled mid-cycle.
  always @(negedge GMII_CLK) begin
    if (RX_VALID) begin
      if (rx_q.size() == 0) first_valid_cyc = cyc;
      rx_q.push_back(RX_DATA);
      if (RX_SOF) begin
        sof_cnt++;
        sof_byte = RX_DATA;
      end
    end
    if (RX_END) begin
      end_cnt++;
      last_good   = RX_GOOD;
      last_status = RX_STATUS;
      if (RX_VALID) end_valid_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic int count_diffs();
    int n;
    n = 0;
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
      if (rx_q[k] !== exp_q[k]) n++;
    end
    return n;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic rst);
    @(negedge GMII_CLK);
    GMII_RX_DV = dv;
    GMII_RXD   = d;
    GMII_RX_ER = er;
    RESET_IN   = rst;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic build_frame(input int n, input bit bad_fcs);
    logic [31:0] c;
    logic [31:0] fcs;
    frame.delete();
    exp_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      frame.push_back(8'(i));
      exp_q.push_back(8'(i));
      c = crc_upd(c, 8'(i));
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) frame.push_back(fcs[8*k +: 8]);
    if (bad_fcs) frame[n] = ~frame[n];
  endtask

  task automatic send_frame(input int er_idx, input int rst_idx);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < frame.size(); i++) begin
      drive(1'b1, frame[i], (i == er_idx), (i == rst_idx));
      if (i == 0) drive_cyc0 = cyc;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    end_cnt         = 0;
    sof_cnt         = 0;
    end_valid_cnt   = 0;
    first_valid_cyc = -1;
  endtask

  task automatic wait_end(input int target, input string name);
    int n;
    n = 0;
    while (end_cnt < target && n < 40) begin
      @(negedge GMII_CLK);
      n++;
    end
    checks++;
    if (end_cnt < target) begin
      errors++;
      $display("[TB] FAIL %s_end_timeout: got %0d RX_END pulses, expected %0d", name, end_cnt, target);
    end
    idle(4);
  endtask

  task automatic test_reset();
    RESET_IN = 1'b1; GMII_RX_DV = 1'b0; GMII_RXD = 8'h00; GMII_RX_ER = 1'b0;
    repeat (3) @(negedge GMII_CLK);
    idle(2);
    checks++;
    if ({RX_VALID, RX_SOF, RX_END, RX_GOOD} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {RX_VALID, RX_SOF, RX_END, RX_GOOD});
    end
    checks++;
    if (RX_DATA !== 8'h00 || RX_STATUS !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got data=%h status=%h expected 00/0", RX_DATA, RX_STATUS);
    end
    checks++;
    if (GOOD_CNT !== 16'd0 || BAD_CNT !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got good=%0d bad=%0d expected 0/0", GOOD_CNT, BAD_CNT);
    end
  endtask

  task automatic test_good_frame();
    clear_mon();
    build_frame(60, 1'b0);
    send_frame(-1, -1);
    wait_end(1, "good");
    checks++;
    if (rx_q.size() !== 60 || count_diffs() !== 0) begin
      errors++;
      $display("[TB] FAIL good_data: got %0d bytes (%0d wrong) expected 60 bytes 00..3b", rx_q.size(), count_diffs());
    end
    checks++;
    if (sof_cnt !== 1 || sof_byte !== 8'h00) begin
      errors++;
      $display("[TB] FAIL good_sof: got count=%0d byte=%h expected 1/00", sof_cnt, sof_byte);
    end
    checks++;
    if (first_valid_cyc - drive_cyc0 !== 6) begin
      errors++;
      $display("[TB] FAIL good_latency: got %0d cycles expected 6", first_valid_cyc - drive_cyc0);
    end
    checks++;
    if (last_good !== 1'b1 || last_status !== 4'b0000 || end_valid_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL good_status: got good=%b status=%b valid_at_end=%0d expected 1/0000/0", last_good, last_status, end_valid_cnt);
    end
    checks++;
    if (GOOD_CNT !== 16'd1 || BAD_CNT !== 16'd0) begin
      errors++;
      $display("[TB] FAIL good_cnt: got good=%0d bad=%0d expected 1/0", GOOD_CNT, BAD_CNT);
    end
  endtask

  task automatic test_bad_fcs();
    clear_mon();
    build_frame(60, 1'b1);
    send_frame(-1, -1);
    wait_end(1, "badfcs");
    checks++;
    if (rx_q.size() !== 60 || count_diffs() !== 0) begin
      errors++;
      $display("[TB] FAIL badfcs_data: got %0d bytes (%0d wrong) expected 60 bytes 00..3b", rx_q.size(), count_diffs());
    end
    checks++;
    if (last_good !== 1'b0 || last_status !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL badfcs_status: got good=%b status=%b expected 0/0001", last_good, last_status);
    end
    checks++;
    if (GOOD_CNT !== 16'd1 || BAD_CNT !== 16'd1) begin
      errors++;
      $display("[TB] FAIL badfcs_cnt: got good=%0d bad=%0d expected 1/1", GOOD_CNT, BAD_CNT);
    end
  endtask

  task automatic test_runt();
    clear_mon();
    build_frame(36, 1'b0);
    send_frame(-1, -1);
    wait_end(1, "runt");
    checks++;
    if (rx_q.size() !== 36 || count_diffs() !== 0) begin
      errors++;
      $display("[TB] FAIL runt_data: got %0d bytes (%0d wrong) expected 36", rx_q.size(), count_diffs());
    end
    checks++;
    if (last_good !== 1'b0 || last_status !== 4'b0010 || BAD_CNT !== 16'd2) begin
      errors++;
      $display("[TB] FAIL runt_status: got good=%b status=%b bad=%0d expected 0/0010/2", last_good, last_status, BAD_CNT);
    end
  endtask

  task automatic test_short_frame();
    logic [31:0] c;
    logic [3:0]  exp_status;
    clear_mon();
    frame.delete();
    frame.push_back(8'h01);
    frame.push_back(8'h02);
    frame.push_back(8'h03);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) c = crc_upd(c, frame[i]);
    exp_status = {3'b001, (c != 32'hDEBB20E3)};
    send_frame(-1, -1);
    wait_end(1, "short");
    checks++;
    if (rx_q.size() !== 0 || sof_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL short_data: got %0d bytes sof=%0d expected 0/0", rx_q.size(), sof_cnt);
    end
    checks++;
    if (last_status !== exp_status || BAD_CNT !== 16'd3) begin
      errors++;
      $display("[TB] FAIL short_status: got status=%b bad=%0d expected %b/3", last_status, BAD_CNT, exp_status);
    end
  endtask

  task automatic test_too_long();
    clear_mon();
    build_frame(1596, 1'b0);
    while (exp_q.size() > 1514) void'(exp_q.pop_back());
    send_frame(-1, -1);
    wait_end(1, "long");
    checks++;
    if (rx_q.size() !== 1514 || count_diffs() !== 0) begin
      errors++;
      $display("[TB] FAIL long_data: got %0d bytes (%0d wrong) expected 1514", rx_q.size(), count_diffs());
    end
    checks++;
    if (last_good !== 1'b0 || last_status !== 4'b0100 || BAD_CNT !== 16'd4) begin
      errors++;
      $display("[TB] FAIL long_status: got good=%b status=%b bad=%0d expected 0/0100/4", last_good, last_status, BAD_CNT);
    end
  endtask

  task automatic test_rx_er();
    clear_mon();
    build_frame(60, 1'b0);
    send_frame(10, -1);
    wait_end(1, "rxer");
    checks++;
    if (last_good !== 1'b0 || last_status !== 4'b1000 || BAD_CNT !== 16'd5) begin
      errors++;
      $display("[TB] FAIL rxer_status: got good=%b status=%b bad=%0d expected 0/1000/5", last_good, last_status, BAD_CNT);
    end
    clear_mon();
    repeat (5) drive(1'b0, 8'h0F, 1'b1, 1'b0);
    idle(10);
    checks++;
    if (end_cnt !== 0 || rx_q.size() !== 0 || GOOD_CNT !== 16'd1 || BAD_CNT !== 16'd5) begin
      errors++;
      $display("[TB] FAIL carrier_ext: got ends=%0d bytes=%0d good=%0d bad=%0d expected 0/0/1/5", end_cnt, rx_q.size(), GOOD_CNT, BAD_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] one_q[$];
    clear_mon();
    build_frame(60, 1'b0);
    one_q = exp_q;
    send_frame(-1, -1);
    send_frame(-1, -1);
    exp_q = {one_q, one_q};
    wait_end(2, "b2b");
    checks++;
    if (end_cnt !== 2 || sof_cnt !== 2 || GOOD_CNT !== 16'd3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got ends=%0d sofs=%0d good=%0d expected 2/2/3", end_cnt, sof_cnt, GOOD_CNT);
    end
    checks++;
    if (rx_q.size() !== 120 || count_diffs() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_data: got %0d bytes (%0d wrong) expected 120", rx_q.size(), count_diffs());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    build_frame(60, 1'b0);
    send_frame(-1, 20);
    idle(20);
    // Bytes 0..14 have already left the pipeline when reset hits at byte 20.
    checks++;
    if (rx_q.size() !== 15 || end_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL rstmid_abort: got bytes=%0d ends=%0d expected 15/0", rx_q.size(), end_cnt);
    end
    checks++;
    if (GOOD_CNT !== 16'd0 || BAD_CNT !== 16'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_cnt: got good=%0d bad=%0d expected 0/0", GOOD_CNT, BAD_CNT);
    end
    clear_mon();
    send_frame(-1, -1);
    wait_end(1, "rstmid_next");
    checks++;
    if (rx_q.size() !== 60 || count_diffs() !== 0 || last_good !== 1'b1 || GOOD_CNT !== 16'd1) begin
      errors++;
      $display("[TB] FAIL rstmid_next: got bytes=%0d wrong=%0d good=%b cnt=%0d expected 60/0/1/1", rx_q.size(), count_diffs(), last_good, GOOD_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_runt();
    test_short_frame();
    test_too_long();
    test_rx_er();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmii_rx_frame_checker.md
Name: gmii_rx_frame_checker

Overview:
- Sits directly downstream of the SGMII PCS/PMA wrapper's GMII receive outputs, in the GMII_CLK domain.
- Strips preamble and SFD and validates each frame: CRC32 check, length limits and RX_ER.
- Emits the payload with FCS removed as a byte stream, plus a per-frame end/status pulse and saturating good/bad frame counters for the SiTCP-side logic.

Parameters:
- MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS).
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS).
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- GMII_CLK  in  1  125 MHz GMII clock; the only clock.
- RESET_IN  in  1  synchronous, active-high reset.
- GMII_RX_DV  in  1  receive data valid from the PCS/PMA.
- GMII_RXD  in  8  receive data.
- GMII_RX_ER  in  1  receive error.
- RX_DATA  out  8  payload byte, FCS excluded.
- RX_VALID  out  1  RX_DATA qualifier.
- RX_SOF  out  1  high with the first payload byte of a frame.
- RX_END  out  1  one-cycle pulse when a frame ends.
- RX_GOOD  out  1  valid with RX_END: frame passed every check.
- RX_STATUS  out  4  valid with RX_END: {er, too_long, runt, crc_bad}.
- GOOD_CNT  out  CNT_W  good frames received, saturating.
- BAD_CNT  out  CNT_W  bad frames received, saturating.

Behaviour:
- Input stage: all GMII inputs are registered once. Every rule below refers to the registered values.
- Reset state: every output is 0, the FSM is in IDLE, the CRC register is 0xFFFFFFFF and the counters are 0.
- IDLE:
  - DV=1 with RXD=0x55 goes to PRE with pcnt=1.
  - DV=1 with any other byte (including 0xD5) goes to DROP.
- PRE:
  - 0x55 increments pcnt, saturating at 7.
  - 0xD5 goes to DATA and initialises the CRC to 0xFFFFFFFF and the byte count to 0.
  - Any other byte, or DV falling, goes to DROP/IDLE with no RX_END.
  - If DV falls during PRE, the block returns to IDLE silently.
- DATA:
  - Each byte updates the CRC with the reflected polynomial 0xEDB88320.
  - The byte count increments and saturates at 2047.
  - Each byte enters a 4-deep delay line. Once the line is full, every new byte pushes out the oldest, which drives RX_DATA with RX_VALID=1.
  - RX_SOF accompanies the first pushed-out byte.
  - No pushed-out bytes are emitted beyond MAX_LEN-4 payload bytes; the remaining bytes are still counted.
  - Latency: a payload byte reaches RX_DATA 6 GMII_CLK cycles after it appears on the GMII pins, for a contiguous frame.
- DATA end (first registered DV=0): goes to IDLE. In that same cycle:
  - RX_END=1 with RX_GOOD and RX_STATUS valid; RX_VALID=0.
  - The 4 bytes left in the delay line are the FCS and are discarded.
- Status bits:
  - crc_bad: final CRC register is not 0xDEBB20E3.
  - runt: byte count < MIN_LEN.
  - too_long: byte count > MAX_LEN.
  - er: RX_ER was high on any DATA cycle with DV=1.
  - RX_GOOD = all status bits are 0.
- Counters: on RX_END, GOOD_CNT or BAD_CNT increments and holds at all-ones.
- DROP: waits for DV=0, then goes to IDLE. No outputs, no counter change.
- Frames with fewer than 5 bytes after the SFD emit no RX_VALID bytes but still produce RX_END with runt (and normally crc_bad) set.
- Back-to-back frames: DV may re-assert the cycle after RX_END. IDLE accepts the new frame with no lost byte.
- RX_ER with DV=0 (carrier extension or false carrier) is ignored in every state.
- Reset mid-frame: the block returns to the reset state immediately. If DV is still high after reset is released, the block enters DROP, so no partial frame is ever emitted.

Decomposition:
- Shared package (gmii_rx_pkg):
  - Constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3.
  - State enum {IDLE, PRE, DATA, DROP}.
  - RX_STATUS bit indices.
- Sub-module crc32_d8: combinational next-CRC function, taking an 8-bit data input and the 32-bit current CRC and producing the next CRC. It is reusable by the TX FCS inserter.

Test Plan:
- 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS -> exactly 60 RX_VALID bytes 0x00..0x3B; RX_SOF on 0x00; RX_END with RX_GOOD=1, RX_STATUS=0; GOOD_CNT=1.
- Same frame with FCS byte 0 inverted -> identical data stream; RX_GOOD=0, RX_STATUS=4'b0001; BAD_CNT=1.
- 40-byte frame with valid FCS -> RX_STATUS=4'b0010 (runt). 1600-byte frame with valid FCS -> RX_STATUS=4'b0100 and at most 1514 RX_VALID bytes.
- RX_ER pulsed on payload byte 10 -> RX_STATUS bit3=1. A separate RX_ER=1 with DV=0 burst -> no RX_END and no counter change.
- Two good frames separated by a single DV=0 cycle -> two RX_END pulses; GOOD_CNT=2; no dropped bytes.
- RESET_IN asserted for 1 cycle at payload byte 20, with DV still high -> no further RX_VALID and no RX_END for that frame; the next good frame is received with GOOD_CNT=1.
